// File: rtl/wdt_pkg.sv
// Shared encodings for the two-stage watchdog supervisor: FSM states,
// register offsets and CTRL bit positions.
package wdt_pkg;

    typedef enum logic [1:0] {
        WDT_IDLE  = 2'd0,
        WDT_WATCH = 2'd1,
        WDT_WARN  = 2'd2,
        WDT_BITE  = 2'd3
    } wdt_state_e;

    localparam logic [1:0] WDT_CTRL    = 2'd0;
    localparam logic [1:0] WDT_TIMEOUT = 2'd1;
    localparam logic [1:0] WDT_KICK    = 2'd2;
    localparam logic [1:0] WDT_STATUS  = 2'd3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_LOCK_BIT = 1;

endpackage

// File: rtl/wdt_down_counter.sv
// 32-bit loadable down-counter; load wins over decrement and the count
// parks at zero instead of wrapping.
module wdt_down_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        dec,
    output logic [31:0] cnt,
    output logic        zero
);

    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != 32'd0)) begin
            cnt_d = cnt_q - 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == 32'd0);

endmodule

// File: rtl/watchdog_supervisor.sv
// Two-stage processor watchdog: register file, escalation FSM and read mux.
// state | meaning
// IDLE  | disabled, counter parked at 0
// WATCH | counting TIMEOUT, waiting for a kick
// WARN  | irq raised, counting GRACE before reset request
// BITE  | irq and rst_req held until rst
module watchdog_supervisor
    import wdt_pkg::*;
#(
    parameter logic [31:0] DEFAULT_TIMEOUT = 32'd150000000,
    parameter logic [31:0] GRACE           = 32'd15000000,
    parameter logic [31:0] KICK_KEY        = 32'h5A5AA5A5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic        rst_req
);

    wdt_state_e  state_q, state_d;
    logic [31:0] timeout_q, timeout_d;
    logic        en_q, en_d;
    logic        lock_q, lock_d;
    logic        irq_q, irq_d;
    logic        rst_req_q, rst_req_d;

    logic        live, ctrl_wr, tmo_wr, kick_wr, en_wr, kick_ok, kick_bad;
    logic        cnt_load, cnt_dec, cnt_zero;
    logic [31:0] cnt_load_val, cnt;

    // BITE freezes the whole register file
    assign live     = (state_q != WDT_BITE);
    assign ctrl_wr  = wr_en && live && (addr == WDT_CTRL);
    assign tmo_wr   = wr_en && live && (addr == WDT_TIMEOUT);
    assign kick_wr  = wr_en && live && (addr == WDT_KICK);
    assign en_wr    = ctrl_wr && !lock_q;
    assign kick_ok  = kick_wr && (wdata == KICK_KEY);
    assign kick_bad = kick_wr && (wdata != KICK_KEY);
    assign cnt_dec  = ((state_q == WDT_WATCH) || (state_q == WDT_WARN)) && (cnt != 32'd0);

    wdt_down_counter u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        timeout_d    = timeout_q;
        en_d         = en_q;
        lock_d       = lock_q;
        irq_d        = irq_q;
        rst_req_d    = rst_req_q;
        cnt_load     = 1'b0;
        cnt_load_val = 32'd0;

        // EN is gated by the old LOCK, so EN=0 with LOCK=1 still disables
        if (en_wr) en_d = wdata[CTRL_EN_BIT];
        if (ctrl_wr) lock_d = lock_q | wdata[CTRL_LOCK_BIT];
        if (tmo_wr && !lock_q) timeout_d = (wdata == 32'd0) ? 32'd1 : wdata;

        case (state_q)
            WDT_IDLE: begin
                if (en_wr && wdata[CTRL_EN_BIT]) begin
                    state_d      = WDT_WATCH;
                    cnt_load     = 1'b1;
                    cnt_load_val = timeout_q;
                end
            end
            WDT_WATCH, WDT_WARN: begin
                if (en_wr && !wdata[CTRL_EN_BIT]) begin
                    state_d  = WDT_IDLE;
                    irq_d    = 1'b0;
                    cnt_load = 1'b1;
                end else if (kick_bad) begin
                    state_d   = WDT_BITE;
                    irq_d     = 1'b1;
                    rst_req_d = 1'b1;
                end else if (kick_ok) begin
                    state_d      = WDT_WATCH;
                    irq_d        = 1'b0;
                    cnt_load     = 1'b1;
                    cnt_load_val = timeout_q;
                end else if (cnt_zero) begin
                    if (state_q == WDT_WATCH) begin
                        state_d      = WDT_WARN;
                        irq_d        = 1'b1;
                        cnt_load     = 1'b1;
                        cnt_load_val = GRACE;
                    end else begin
                        state_d   = WDT_BITE;
                        irq_d     = 1'b1;
                        rst_req_d = 1'b1;
                    end
                end
            end
            default: begin
                irq_d     = 1'b1;
                rst_req_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= WDT_IDLE;
            timeout_q <= DEFAULT_TIMEOUT;
            en_q      <= 1'b0;
            lock_q    <= 1'b0;
            irq_q     <= 1'b0;
            rst_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timeout_q <= timeout_d;
            en_q      <= en_d;
            lock_q    <= lock_d;
            irq_q     <= irq_d;
            rst_req_q <= rst_req_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr)
            WDT_CTRL:    rdata = {30'd0, lock_q, en_q};
            WDT_TIMEOUT: rdata = timeout_q;
            WDT_STATUS:  rdata = {28'd0, irq_q, rst_req_q, state_q};
            default:     rdata = 32'd0;
        endcase
    end

    assign irq     = irq_q;
    assign rst_req = rst_req_q;

endmodule

// File: doc/watchdog_supervisor.md
# watchdog_supervisor

Memory-mapped supervisor that sequences a two-stage processor watchdog: software enables it, programs a timeout, and periodically "kicks" it with a key. A missed deadline first raises a warning interrupt. A further missed grace period raises a held system-reset request. It sits on the processor's peripheral register bus next to the interrupt controller. `irq` feeds the trap logic and `rst_req` feeds the board reset generator.

## Interface
- `DEFAULT_TIMEOUT`, default 32'd150000000: WATCH-stage cycle budget loaded at reset.
- `GRACE`, default 32'd15000000: WARN-stage cycle budget; fixed, not software-visible.
- `KICK_KEY`, default 32'h5A5AA5A5: only value accepted as a valid kick.
- `clk` in 1: clock.
- `rst` in 1: reset; asynchronous, active-low.
- `wr_en` in 1: register write strobe, one cycle per write.
- `addr` in 2: register select. 0 = CTRL, 1 = TIMEOUT, 2 = KICK, 3 = STATUS.
- `wdata` in 32: write data.
- `rdata` out 32: combinational read of `addr`.
- `irq` out 1: warning interrupt, registered.
- `rst_req` out 1: system reset request, registered, held.

## Operation
- Registers:
  - CTRL: bit0 EN, bit1 LOCK.
    - LOCK is set-only; it clears only on `rst`.
    - While LOCK=1, writes to CTRL.EN and TIMEOUT are ignored.
  - TIMEOUT: 32-bit reload value, reset value `DEFAULT_TIMEOUT`. A written value of 0 is stored as 1.
  - KICK: write-only; reads return 0.
  - STATUS: read-only, returns {28'd0, irq, rst_req, state[1:0]}. Reading the counter is not supported.
- States (2-bit encoding): IDLE=0, WATCH=1, WARN=2, BITE=3. The counter `cnt` is 32-bit and counts down.
- IDLE:
  - `cnt`=0, `irq`=0.
  - A CTRL write with EN=1 moves to WATCH and sets `cnt`=TIMEOUT.
- WATCH:
  - `cnt` decrements by 1 each cycle.
  - A valid kick reloads `cnt`=TIMEOUT.
  - When `cnt`==0 with no kick in that cycle: go to WARN, set `cnt`=GRACE, `irq`<=1.
- WARN:
  - `cnt` decrements by 1 each cycle.
  - A valid kick returns to WATCH, reloads TIMEOUT, and sets `irq`<=0.
  - When `cnt`==0 with no kick: go to BITE, `rst_req`<=1.
- BITE:
  - Terminal state; only `rst` exits it.
  - `rst_req` and `irq` are held at 1. All writes are ignored.
- Invalid kick: a KICK write with `wdata`!=KICK_KEY in WATCH or WARN goes directly to BITE on the next edge. In IDLE it is ignored.
- Disable: a CTRL write with EN=0 in WATCH or WARN while LOCK=0 goes to IDLE and clears `irq`.
- TIMEOUT writes in WATCH or WARN (when unlocked) update the register only. They take effect at the next reload.
- Counter arithmetic: `cnt` never wraps, because decrement happens only when `cnt`!=0.

## Timing
- Reset values: state=IDLE, `cnt`=0, TIMEOUT=`DEFAULT_TIMEOUT`, EN=0, LOCK=0, `irq`=0, `rst_req`=0, `rdata` follows `addr` (STATUS reads 0).
- Writes take effect at the edge where `wr_en`=1. The new state is visible on the next cycle.
- Enable with TIMEOUT=T and no kicks: `irq` rises T+1 cycles after the enabling edge. `rst_req` rises GRACE+1 cycles after `irq` rises.
- A kick on the same cycle as `cnt`==0 takes priority over expiry: no escalation occurs.
- Setting EN=0 and LOCK=1 in one CTRL write: the EN change is applied first, then LOCK latches.
- An EN=1 write in WATCH or WARN is a no-op and does not reload the counter.
- Reset asserted mid-operation, including in BITE: all state clears asynchronously.

## Structure
- Shared package `wdt_pkg` holds:
  - the state encoding (`WDT_IDLE`…`WDT_BITE`);
  - the register offsets (`WDT_CTRL`, `WDT_TIMEOUT`, `WDT_KICK`, `WDT_STATUS`);
  - the CTRL bit indices.
- One sub-module, `wdt_down_counter`: a 32-bit loadable down-counter with `load`, `load_val`, `dec`, `cnt`, and `zero` ports, using the same async active-low reset. The FSM, register file and read mux stay in the top level.

## Test plan
- Parameters for the bench: TIMEOUT=10, GRACE=5.
  - Enable, no kicks: `irq`=1 exactly 11 cycles after the EN write, then `rst_req`=1 6 cycles later, STATUS=0xF.
- Kick with KICK_KEY every 8 cycles for 100 cycles: `irq` stays 0 and STATUS=0x1. A kick issued on the `cnt`==0 cycle also prevents `irq`.
- Let WARN assert, then kick with the key: `irq` falls next cycle, STATUS=0x1, and a full TIMEOUT restarts.
- Write 0x12345678 to KICK in WATCH: next cycle STATUS=0xF and `rst_req`=1. A later CTRL write of EN=0 does not leave BITE.
- Set LOCK, then write EN=0 and TIMEOUT=3: both are ignored, and expiry still occurs at the original 10-cycle budget.
- Pulse `rst` low in BITE: `rst_req`=0 and `irq`=0 immediately; TIMEOUT reads back `DEFAULT_TIMEOUT`, LOCK=0.
